// File: rtl/vga_display_driver.sv
// vga_display_driver
//   Reader side of the character screen memory. Generates 640x480@60Hz VGA timing from the
//   system clock and shows a XCHARS x YCHARS grid of 16x16-pixel tiles. Each pixel position
//   produces a screen-memory address. The returned character code, together with the pixel's
//   offset inside its tile, addresses an external bitmap memory. The colour read back is
//   registered and driven out as RGB.
//
//   Optional feature macro: VGA_FRAME_TICK_EN
//     defined   -> frame_tick output exists. It is a one-clock pulse at the start of vertical
//                  blank, for CPU frame pacing.
//     undefined -> no frame_tick port and no related logic.
//
// Ports
//   clock         in   1              system clock
//   reset_n       in   1              asynchronous active-low reset
//   vga_addr      out  $clog2(Nloc)   screen-memory address (memory reads combinationally)
//   vga_readdata  in   Dbits          character code at vga_addr
//   bmem_addr     out  Dbits+8        {charcode, tile_row[3:0], tile_col[3:0]}
//   bmem_color    in   12             {R,G,B}, 4 bits each, combinational from bmem_addr
//   hsync         out  1              horizontal sync, active low
//   vsync         out  1              vertical sync, active low
//   red/green/blue out 4 each         pixel colour
//   frame_tick    out  1              only with VGA_FRAME_TICK_EN
module vga_display_driver #(
    parameter int unsigned Nloc   = 1200,
    parameter int unsigned Dbits  = 4,
    parameter int unsigned XCHARS = 40,
    parameter int unsigned YCHARS = 30,
    parameter int unsigned CLKDIV = 4,
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33
) (
    input  logic                      clock,
    input  logic                      reset_n,
    output logic [$clog2(Nloc)-1:0]   vga_addr,
    input  logic [Dbits-1:0]          vga_readdata,
    output logic [Dbits+7:0]          bmem_addr,
    input  logic [11:0]               bmem_color,
    output logic                      hsync,
    output logic                      vsync,
    output logic [3:0]                red,
    output logic [3:0]                green,
    output logic [3:0]                blue
`ifdef VGA_FRAME_TICK_EN
    ,
    output logic                      frame_tick
`endif
);

    localparam int unsigned AW = $clog2(Nloc);
    localparam int unsigned DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    // The active region is clipped to the tile grid as well as to the visible area, so that
    // vga_addr can never point past the last screen-memory location.
    localparam int unsigned HAct = (H_VIS < XCHARS * 16) ? H_VIS : XCHARS * 16;
    localparam int unsigned VAct = (V_VIS < YCHARS * 16) ? V_VIS : YCHARS * 16;

    localparam logic [DW-1:0] DivLast    = DW'(CLKDIV - 1);
    localparam logic [9:0]    HLast      = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]    VLast      = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0]    HActEnd    = 10'(HAct);
    localparam logic [9:0]    VActEnd    = 10'(VAct);
    localparam logic [9:0]    HSyncFirst = 10'(H_VIS + H_FP);
    localparam logic [9:0]    HSyncLast  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0]    VSyncFirst = 10'(V_VIS + V_FP);
    localparam logic [9:0]    VSyncLast  = 10'(V_VIS + V_FP + V_SYNC - 1);
`ifdef VGA_FRAME_TICK_EN
    localparam logic [9:0]    VBlankLine = 10'(V_VIS);
`endif

    logic [DW-1:0] div_q;
    logic [9:0]    x_q;
    logic [9:0]    y_q;
    logic          hsync_q;
    logic          vsync_q;
    logic [11:0]   rgb_q;
`ifdef VGA_FRAME_TICK_EN
    logic          frame_tick_q;
`endif

    logic          pix_en;
    logic          active;
    logic          x_wrap;
    logic          y_wrap;
    logic [AW-1:0] row_base;

    // Pixel strobe: one system clock out of every CLKDIV.
    assign pix_en = (div_q == DivLast);
    assign x_wrap = (x_q == HLast);
    assign y_wrap = (y_q == VLast);

    // Screen-memory and bitmap addressing, combinational from the current counters.
    always_comb begin
        active   = (x_q < HActEnd) && (y_q < VActEnd);
        // Row base sized to the address width; the largest product fits by construction.
        row_base = AW'(y_q[9:4]) * AW'(XCHARS);
        vga_addr = '0;
        if (active) begin
            vga_addr = row_base + AW'(x_q[9:4]);
        end
    end

    assign bmem_addr = {vga_readdata, y_q[3:0], x_q[3:0]};

    // Timing counters and the output register. The output register samples the current pixel,
    // so colour and both syncs appear one pixel after the counters and stay aligned.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            rgb_q        <= 12'h000;
`ifdef VGA_FRAME_TICK_EN
            frame_tick_q <= 1'b0;
`endif
        end else begin
            div_q <= pix_en ? '0 : div_q + DW'(1);
`ifdef VGA_FRAME_TICK_EN
            // One system clock wide: cleared on every clock that is not the capture edge.
            frame_tick_q <= pix_en && (x_q == 10'd0) && (y_q == VBlankLine);
`endif
            if (pix_en) begin
                x_q <= x_wrap ? 10'd0 : x_q + 10'd1;
                if (x_wrap) begin
                    y_q <= y_wrap ? 10'd0 : y_q + 10'd1;
                end
                rgb_q   <= active ? bmem_color : 12'h000;
                hsync_q <= ~((x_q >= HSyncFirst) && (x_q <= HSyncLast));
                vsync_q <= ~((y_q >= VSyncFirst) && (y_q <= VSyncLast));
            end
        end
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign red   = rgb_q[11:8];
    assign green = rgb_q[7:4];
    assign blue  = rgb_q[3:0];
`ifdef VGA_FRAME_TICK_EN
    assign frame_tick = frame_tick_q;
`endif

endmodule
